mem_stage: RTL and testbench

Memory stage of the 16-bit pipelined CPU. It consumes the X/M pipeline register, drives a multi-cycle data-memory handshake for loads and stores, and stalls the upstream pipeline while an access is outstanding. It also produces the M/W pipeline register consumed by writeback, and carries the sticky processor halt that drives the top-level `hlt`.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/mw_pipe_reg.sv | 24 ++
 rtl/mem_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and widths for the 16-bit pipelined CPU.
package cpu_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned REG_W  = 4;

    typedef enum logic [1:0] {
        MS_IDLE   = 2'd0,
        MS_WAIT   = 2'd1,
        MS_HALTED = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] instr;
        logic              reg_write;
        logic [REG_W-1:0]  reg_dest;
        logic [WORD_W-1:0] data;
        logic              halt;
    } mw_bus_t;

endpackage

// File: rtl/mw_pipe_reg.sv
// M/W pipeline register. A bubble clears only the control bits; payload fields hold.
module mw_pipe_reg
    import cpu_pkg::*;
(
    input  logic    clk,
    input  logic    clear,
    input  logic    bubble,
    input  mw_bus_t d,
    output mw_bus_t q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else if (bubble) begin
            q.valid     <= 1'b0;
            q.reg_write <= 1'b0;
            q.halt      <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: multi-cycle data-memory handshake, upstream stall, M/W register and sticky halt.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DW = WORD_W,
    parameter int unsigned RW = REG_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          xm_valid,
    input  logic [DW-1:0] xm_instr,
    input  logic          xm_mem_read,
    input  logic          xm_mem_write,
    input  logic          xm_reg_write,
    input  logic [RW-1:0] xm_reg_dest,
    input  logic [DW-1:0] xm_alu_result,
    input  logic [DW-1:0] xm_store_data,
    input  logic          xm_halt,
    output logic          stall,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ack,
    output logic          mw_valid,
    output logic [DW-1:0] mw_instr,
    output logic          mw_reg_write,
    output logic [RW-1:0] mw_reg_dest,
    output logic [DW-1:0] mw_data,
    output logic          mw_halt,
    output logic          hlt
);

    mem_state_t    stateQ, stateD;
    logic          reqWeQ;
    logic          isLoadQ;
    logic [DW-1:0] reqAddrQ;
    logic [DW-1:0] reqWdataQ;
    logic [DW-1:0] instrQ;
    logic          regWriteQ;
    logic [RW-1:0] regDestQ;
    logic          hltQ;

    logic          memOp;
    logic          latchReq;
    logic          stallRaw;
    logic          reqRaw;
    logic          weRaw;
    logic          mwBubble;
    mw_bus_t       mwD;
    mw_bus_t       mwQ;

    assign memOp = xm_valid & (xm_mem_read | xm_mem_write);

    always_comb begin
        stateD     = stateQ;
        latchReq   = 1'b0;
        stallRaw   = 1'b0;
        reqRaw     = 1'b0;
        weRaw      = 1'b0;
        dmem_addr  = reqAddrQ;
        dmem_wdata = reqWdataQ;
        mwBubble   = 1'b1;
        mwD        = '0;
        case (stateQ)
            MS_IDLE: begin
                if (memOp) begin
                    // First request cycle comes straight from X/M; later cycles replay the latch.
                    reqRaw     = 1'b1;
                    weRaw      = xm_mem_write;
                    dmem_addr  = xm_alu_result;
                    dmem_wdata = xm_store_data;
                    stallRaw   = 1'b1;
                    latchReq   = 1'b1;
                    stateD     = MS_WAIT;
                end else if (xm_valid) begin
                    mwBubble      = 1'b0;
                    mwD.valid     = 1'b1;
                    mwD.instr     = xm_instr;
                    mwD.reg_write = xm_reg_write;
                    mwD.reg_dest  = xm_reg_dest;
                    mwD.data      = xm_alu_result;
                    mwD.halt      = xm_halt;
                    if (xm_halt) begin
                        stateD = MS_HALTED;
                    end
                end
            end
            MS_WAIT: begin
                reqRaw = 1'b1;
                weRaw  = reqWeQ;
                if (dmem_ack) begin
                    mwBubble      = 1'b0;
                    mwD.valid     = 1'b1;
                    mwD.instr     = instrQ;
                    mwD.reg_write = regWriteQ;
                    mwD.reg_dest  = regDestQ;
                    mwD.data      = isLoadQ ? dmem_rdata : reqAddrQ;
                    stateD        = MS_IDLE;
                end else begin
                    stallRaw = 1'b1;
                end
            end
            MS_HALTED: begin
                stallRaw = 1'b1;
            end
            default: begin
                stateD = MS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ    <= MS_IDLE;
            hltQ      <= 1'b0;
            reqWeQ    <= 1'b0;
            isLoadQ   <= 1'b0;
            reqAddrQ  <= '0;
            reqWdataQ <= '0;
            instrQ    <= '0;
            regWriteQ <= 1'b0;
            regDestQ  <= '0;
        end else begin
            stateQ <= stateD;
            if (stateD == MS_HALTED) begin
                hltQ <= 1'b1;
            end
            if (latchReq) begin
                reqWeQ    <= xm_mem_write;
                // Read together with write is a store.
                isLoadQ   <= xm_mem_read & ~xm_mem_write;
                reqAddrQ  <= xm_alu_result;
                reqWdataQ <= xm_store_data;
                instrQ    <= xm_instr;
                regWriteQ <= xm_reg_write;
                regDestQ  <= xm_reg_dest;
            end
        end
    end

    mw_pipe_reg u_mw_pipe_reg (
        .clk    (clk),
        .clear  (~rst_n),
        .bubble (mwBubble),
        .d      (mwD),
        .q      (mwQ)
    );

    assign stall        = stallRaw & rst_n;
    assign dmem_req     = reqRaw & rst_n;
    assign dmem_we      = weRaw & rst_n;
    assign mw_valid     = mwQ.valid;
    assign mw_instr     = mwQ.instr;
    assign mw_reg_write = mwQ.reg_write;
    assign mw_reg_dest  = mwQ.reg_dest;
    assign mw_data      = mwQ.data;
    assign mw_halt      = mwQ.halt;
    assign hlt          = hltQ;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle ops plus multi-cycle memory sequences.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        xm_valid;
    logic [15:0] xm_instr;
    logic        xm_mem_read;
    logic        xm_mem_write;
    logic        xm_reg_write;
    logic [3:0]  xm_reg_dest;
    logic [15:0] xm_alu_result;
    logic [15:0] xm_store_data;
    logic        xm_halt;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ack;
    logic        mw_valid;
    logic [15:0] mw_instr;
    logic        mw_reg_write;
    logic [3:0]  mw_reg_dest;
    logic [15:0] mw_data;
    logic        mw_halt;
    logic        hlt;

    int errors = 0;
    int checks = 0;

    mem_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .xm_valid      (xm_valid),
        .xm_instr      (xm_instr),
        .xm_mem_read   (xm_mem_read),
        .xm_mem_write  (xm_mem_write),
        .xm_reg_write  (xm_reg_write),
        .xm_reg_dest   (xm_reg_dest),
        .xm_alu_result (xm_alu_result),
        .xm_store_data (xm_store_data),
        .xm_halt       (xm_halt),
        .stall         (stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .mw_valid      (mw_valid),
        .mw_instr      (mw_instr),
        .mw_reg_write  (mw_reg_write),
        .mw_reg_dest   (mw_reg_dest),
        .mw_data       (mw_data),
        .mw_halt       (mw_halt),
        .hlt           (hlt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        rw;
        logic [3:0]  dest;
        logic [15:0] alu;
        logic        chkData;
        logic        eValid;
        logic        eRw;
        logic [3:0]  eDest;
        logic [15:0] eData;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instruction word is a fixed function of the address/result so M/W trace can be checked.
    task automatic drive(input logic v, input logic rd, input logic wr, input logic rw,
                         input logic [3:0] dest, input logic [15:0] alu,
                         input logic [15:0] sdata, input logic h);
        xm_valid      = v;
        xm_mem_read   = rd;
        xm_mem_write  = wr;
        xm_reg_write  = rw;
        xm_reg_dest   = dest;
        xm_alu_result = alu;
        xm_store_data = sdata;
        xm_halt       = h;
        xm_instr      = alu ^ 16'h5A5A;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 4'd3,  16'h1234, 1'b1, 1'b1, 1'b1, 4'd3,  16'h1234};
        vecs[1] = '{1'b1, 1'b0, 4'd7,  16'hFFFF, 1'b1, 1'b1, 1'b0, 4'd7,  16'hFFFF};
        vecs[2] = '{1'b0, 1'b1, 4'd5,  16'h5555, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0000};
        vecs[3] = '{1'b1, 1'b1, 4'd15, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd15, 16'h0000};
        vecs[4] = '{1'b1, 1'b1, 4'd0,  16'h8001, 1'b1, 1'b1, 1'b1, 4'd0,  16'h8001};

        rst_n      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 16'h0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_stall", stall, 0);
        check("reset_req", dmem_req, 0);
        check("reset_mw_valid", mw_valid, 0);
        check("reset_mw_data", mw_data, 0);
        check("reset_hlt", hlt, 0);
        tick();
        rst_n = 1'b1;

        // Non-memory ops: one-cycle latency, never stall.
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].valid, 1'b0, 1'b0, vecs[i].rw, vecs[i].dest, vecs[i].alu,
                  16'h0, 1'b0);
            @(negedge clk);
            check($sformatf("alu%0d_stall", i), stall, 0);
            check($sformatf("alu%0d_req", i), dmem_req, 0);
            tick();
            check($sformatf("alu%0d_mw_valid", i), mw_valid, vecs[i].eValid);
            check($sformatf("alu%0d_mw_rw", i), mw_reg_write, vecs[i].eRw);
            if (vecs[i].chkData) begin
                check($sformatf("alu%0d_mw_dest", i), mw_reg_dest, vecs[i].eDest);
                check($sformatf("alu%0d_mw_data", i), mw_data, vecs[i].eData);
                check($sformatf("alu%0d_mw_instr", i), mw_instr, vecs[i].alu ^ 16'h5A5A);
            end
        end

        // Load, ack three cycles after the first request cycle.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 16'h0040, 16'h1111, 1'b0);
        for (int k = 0; k < 4; k++) begin
            dmem_ack   = (k == 3);
            dmem_rdata = (k == 3) ? 16'hBEEF : 16'hDEAD;
            @(negedge clk);
            check($sformatf("ld_c%0d_req", k), dmem_req, 1);
            check($sformatf("ld_c%0d_we", k), dmem_we, 0);
            check($sformatf("ld_c%0d_addr", k), dmem_addr, 16'h0040);
            check($sformatf("ld_c%0d_stall", k), stall, (k < 3) ? 1 : 0);
            tick();
            if (k < 3) check($sformatf("ld_c%0d_bubble", k), mw_valid, 0);
        end
        check("ld_mw_valid", mw_valid, 1);
        check("ld_mw_data", mw_data, 16'hBEEF);
        check("ld_mw_dest", mw_reg_dest, 2);
        check("ld_mw_rw", mw_reg_write, 1);
        check("ld_mw_instr", mw_instr, 16'h5A1A);
        dmem_ack = 1'b0;

        // Store with read also set (must act as store), ack one cycle after request.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 16'h0010, 16'h00A5, 1'b0);
        for (int k = 0; k < 2; k++) begin
            dmem_ack   = (k == 1);
            dmem_rdata = 16'hDEAD;
            @(negedge clk);
            check($sformatf("st_c%0d_req", k), dmem_req, 1);
            check($sformatf("st_c%0d_we", k), dmem_we, 1);
            check($sformatf("st_c%0d_wdata", k), dmem_wdata, 16'h00A5);
            check($sformatf("st_c%0d_addr", k), dmem_addr, 16'h0010);
            check($sformatf("st_c%0d_stall", k), stall, (k == 0) ? 1 : 0);
            tick();
        end
        check("st_mw_valid", mw_valid, 1);
        check("st_mw_rw", mw_reg_write, 0);
        check("st_mw_data", mw_data, 16'h0010);
        dmem_ack = 1'b0;

        // Load then store back to back.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 16'h0020, 16'h0, 1'b0);
        @(negedge clk);
        check("b2b_ld_req", dmem_req, 1);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 16'h1357;
        @(negedge clk);
        check("b2b_ack_addr", dmem_addr, 16'h0020);
        check("b2b_ack_we", dmem_we, 0);
        tick();
        check("b2b_ld_data", mw_data, 16'h1357);
        dmem_ack = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 16'h0030, 16'h2468, 1'b0);
        @(negedge clk);
        check("b2b_st_req", dmem_req, 1);
        check("b2b_st_addr", dmem_addr, 16'h0030);
        check("b2b_st_we", dmem_we, 1);
        check("b2b_st_stall", stall, 1);
        tick();
        check("b2b_st_bubble", mw_valid, 0);
        dmem_ack = 1'b1;
        @(negedge clk);
        check("b2b_st_wdata", dmem_wdata, 16'h2468);
        tick();
        check("b2b_st_mw_data", mw_data, 16'h0030);
        dmem_ack = 1'b0;

        // Reset during MS_WAIT, then a stray ack.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd8, 16'h0060, 16'h7777, 1'b0);
        tick();
        @(negedge clk);
        check("rst_wait_req_pre", dmem_req, 1);
        check("rst_wait_we_pre", dmem_we, 1);
        rst_n = 1'b0;
        #1;
        check("rst_wait_req", dmem_req, 0);
        check("rst_wait_we", dmem_we, 0);
        check("rst_wait_stall", stall, 0);
        tick();
        check("rst_wait_mw_valid", mw_valid, 0);
        check("rst_wait_mw_data", mw_data, 0);
        check("rst_wait_mw_instr", mw_instr, 0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
        dmem_ack   = 1'b1;
        dmem_rdata = 16'hFFFF;
        @(negedge clk);
        check("stray_ack_req", dmem_req, 0);
        tick();
        check("stray_ack_mw_valid", mw_valid, 0);
        check("stray_ack_mw_rw", mw_reg_write, 0);
        check("stray_ack_mw_data", mw_data, 0);
        dmem_ack = 1'b0;

        // Halt, then loads must not issue.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h00FF, 16'h0, 1'b1);
        @(negedge clk);
        check("hlt_stall", stall, 0);
        check("hlt_pre", hlt, 0);
        tick();
        check("hlt_mw_halt", mw_halt, 1);
        check("hlt_mw_valid", mw_valid, 1);
        check("hlt_flag", hlt, 1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 16'h0050, 16'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            dmem_ack = (k == 1);
            @(negedge clk);
            check($sformatf("halted_c%0d_req", k), dmem_req, 0);
            check($sformatf("halted_c%0d_stall", k), stall, 1);
            tick();
            check($sformatf("halted_c%0d_hlt", k), hlt, 1);
            check($sformatf("halted_c%0d_mw_valid", k), mw_valid, 0);
            check($sformatf("halted_c%0d_mw_halt", k), mw_halt, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
